// File: rtl/audio_out_sched.sv
// ---------------------------------------------------------------------------
// audio_out_sched
//   Sample-rate scheduler and stereo mixer that feeds the audio_out FIFO.
//   A free-running divider makes one tick per sample period. On each tick the
//   block polls every enabled voice in index order, sums the signed left and
//   right samples into 36-bit accumulators, clamps them to 32 bits and writes
//   one packed frame {left, right} into the FIFO. The FIFO's wrfull is honoured.
//   Missed periods and voice timeouts are counted with saturation.
//
// Ports
//   clk           system clock
//   aclr          asynchronous active-high reset
//   enable        run scheduler; low holds the divider at 0 and aborts a frame
//   voice_en      per-voice enable mask, captured when a frame starts
//   voice_req     one-hot request to the voice being polled (registered)
//   voice_ack     polled voice presents voice_sample this cycle (may be comb.)
//   voice_sample  [63:32] left, [31:0] right, signed two's complement
//   sample        mixed frame, same packing, held between SAT updates
//   wrreq         one-cycle write strobe to the FIFO
//   wrfull        FIFO full
//   missed_cnt    saturating count of ticks dropped while a frame was busy
//   timeout_cnt   saturating count of voice polls that timed out
// ---------------------------------------------------------------------------
module audio_out_sched #(
   parameter int NUM_VOICES = 4,
   parameter int DIV        = 1042,
   parameter int TIMEOUT    = 16
) (
   input  logic                  clk,
   input  logic                  aclr,
   input  logic                  enable,
   input  logic [NUM_VOICES-1:0] voice_en,
   output logic [NUM_VOICES-1:0] voice_req,
   input  logic                  voice_ack,
   input  logic [63:0]           voice_sample,
   output logic [63:0]           sample,
   output logic                  wrreq,
   input  logic                  wrfull,
   output logic [15:0]           missed_cnt,
   output logic [15:0]           timeout_cnt
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   // Index must be able to hold NUM_VOICES: that value marks the extra
   // request-low cycle that follows the last voice's ack or timeout.
   localparam int IW = (NUM_VOICES > 0) ? $clog2(NUM_VOICES + 1) : 1;
   localparam int WW = $clog2(TIMEOUT + 1);

   localparam logic signed [35:0] SAT_MAX = 36'sh0_7FFF_FFFF;
   localparam logic signed [35:0] SAT_MIN = 36'shF_8000_0000;

   typedef enum logic [1:0] {IDLE, POLL, SAT, WRITE} state_t;

   state_t                  state_q, state_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic [NUM_VOICES-1:0]   en_q, en_d;
   logic [NUM_VOICES-1:0]   req_q, req_d;
   logic [IW-1:0]           idx_q, idx_d;
   logic [WW-1:0]           wait_q, wait_d;
   logic signed [35:0]      acc_l_q, acc_l_d;
   logic signed [35:0]      acc_r_q, acc_r_d;
   logic [63:0]             sample_q, sample_d;
   logic [15:0]             missed_q, missed_d;
   logic [15:0]             tmo_q, tmo_d;

   logic                    tick;
   logic                    wr;
   logic                    cur_en;
   logic signed [35:0]      add_l, add_r;

   function automatic logic [31:0] sat32(input logic signed [35:0] a);
      if (a > SAT_MAX)
         sat32 = 32'h7FFF_FFFF;
      else if (a < SAT_MIN)
         sat32 = 32'h8000_0000;
      else
         sat32 = a[31:0];
   endfunction

   always_comb begin
      tick   = enable && (cnt_q == CW'(DIV - 1));
      add_l  = {{4{voice_sample[63]}}, voice_sample[63:32]};
      add_r  = {{4{voice_sample[31]}}, voice_sample[31:0]};
      // Zero once idx reaches NUM_VOICES, so that slot reads as disabled.
      cur_en = |(en_q & (NUM_VOICES'(1) << idx_q));
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      en_d     = en_q;
      req_d    = req_q;
      idx_d    = idx_q;
      wait_d   = wait_q;
      acc_l_d  = acc_l_q;
      acc_r_d  = acc_r_q;
      sample_d = sample_q;
      missed_d = missed_q;
      tmo_d    = tmo_q;
      wr       = 1'b0;

      if (!enable)
         cnt_d = '0;
      else if (tick)
         cnt_d = '0;
      else
         cnt_d = cnt_q + CW'(1);

      // Any tick outside IDLE is dropped, including the WRITE->IDLE cycle.
      if (tick && state_q != IDLE && missed_q != 16'hFFFF)
         missed_d = missed_q + 16'd1;

      if (!enable) begin
         state_d = IDLE;
         req_d   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (tick) begin
                  en_d    = voice_en;
                  acc_l_d = '0;
                  acc_r_d = '0;
                  idx_d   = '0;
                  wait_d  = '0;
                  // Voice 0 is requested straight away so its request lands
                  // in the first POLL cycle.
                  req_d   = {{(NUM_VOICES-1){1'b0}}, voice_en[0]};
                  state_d = POLL;
               end
            end
            POLL: begin
               if (idx_q == IW'(NUM_VOICES)) begin
                  state_d = SAT;
               end else if (req_q != '0) begin
                  if (voice_ack) begin
                     acc_l_d = acc_l_q + add_l;
                     acc_r_d = acc_r_q + add_r;
                     req_d   = '0;
                     idx_d   = idx_q + IW'(1);
                  end else if (wait_q == WW'(TIMEOUT - 1)) begin
                     if (tmo_q != 16'hFFFF)
                        tmo_d = tmo_q + 16'd1;
                     req_d = '0;
                     idx_d = idx_q + IW'(1);
                  end else begin
                     wait_d = wait_q + WW'(1);
                  end
               end else if (cur_en) begin
                  req_d  = NUM_VOICES'(1) << idx_q;
                  wait_d = '0;
               end else if (idx_q == IW'(NUM_VOICES - 1)) begin
                  state_d = SAT;
               end else begin
                  idx_d = idx_q + IW'(1);
               end
            end
            SAT: begin
               sample_d = {sat32(acc_l_q), sat32(acc_r_q)};
               state_d  = WRITE;
            end
            WRITE: begin
               if (!wrfull) begin
                  wr      = 1'b1;
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge aclr) begin
      if (aclr)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   always_ff @(posedge clk or posedge aclr) begin
      if (aclr) begin
         cnt_q    <= '0;
         en_q     <= '0;
         req_q    <= '0;
         idx_q    <= '0;
         wait_q   <= '0;
         acc_l_q  <= '0;
         acc_r_q  <= '0;
         sample_q <= '0;
         missed_q <= '0;
         tmo_q    <= '0;
      end else begin
         cnt_q    <= cnt_d;
         en_q     <= en_d;
         req_q    <= req_d;
         idx_q    <= idx_d;
         wait_q   <= wait_d;
         acc_l_q  <= acc_l_d;
         acc_r_q  <= acc_r_d;
         sample_q <= sample_d;
         missed_q <= missed_d;
         tmo_q    <= tmo_d;
      end
   end

   assign voice_req   = req_q;
   assign sample      = sample_q;
   assign wrreq       = wr;
   assign missed_cnt  = missed_q;
   assign timeout_cnt = tmo_q;

endmodule

// File: tb/tb_audio_out_sched.sv
// ---------------------------------------------------------------------------
// tb_audio_out_sched
//   Directed bench for audio_out_sched. A frame-level model predicts, from the
//   tick time, the captured enable mask and each voice's ack behaviour, the
//   request windows, the SAT cycle, the mixed sample and the counters; a
//   compare loop checks the DUT against it on every falling clock edge.
//   Literal expectations for each scenario pin the model itself.
// ---------------------------------------------------------------------------
module tb_audio_out_sched;
   localparam int N   = 4;
   localparam int DIV = 1042;
   localparam int TMO = 16;

   logic          clk = 1'b0;
   logic          aclr, enable, voice_ack, wrreq, wrfull, spur;
   logic [N-1:0]  voice_en, voice_req, ack_mask, req_ever;
   logic [63:0]   voice_sample, sample;
   logic [15:0]   missed_cnt, timeout_cnt;
   logic [31:0]   vl [N];
   logic [31:0]   vr [N];

   int errors = 0, checks = 0, cyc = 0;
   int n_wr = 0, n_tick = 0, wr_cyc = 0, tick_cyc = 0;
   int req_hi [N];

   // model state
   int          mcnt, k, sat_k;
   bit          busy;
   int          rfrom [N];
   int          rto [N];
   bit          tmo_v [N];
   logic [63:0] fsum, exp_sample;
   int          exp_missed, exp_tmo;

   audio_out_sched #(.NUM_VOICES(N), .DIV(DIV), .TIMEOUT(TMO)) dut (
      .clk(clk), .aclr(aclr), .enable(enable), .voice_en(voice_en),
      .voice_req(voice_req), .voice_ack(voice_ack), .voice_sample(voice_sample),
      .sample(sample), .wrreq(wrreq), .wrfull(wrfull),
      .missed_cnt(missed_cnt), .timeout_cnt(timeout_cnt));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Voices answer combinationally; spur forces ack high even with no request.
   always_comb begin
      voice_ack    = spur | (|(voice_req & ack_mask));
      voice_sample = 64'hDEAD_BEEF_DEAD_BEEF;
      for (int i = 0; i < N; i++)
         if (voice_req[i]) voice_sample = {vl[i], vr[i]};
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] clamp(input longint v);
      if (v > 64'sd2147483647)       return 32'h7FFF_FFFF;
      else if (v < -64'sd2147483648) return 32'h8000_0000;
      else                           return 32'(v);
   endfunction

   task automatic model_reset();
      busy = 0; mcnt = 0; k = 0; sat_k = 0;
      exp_sample = '0; exp_missed = 0; exp_tmo = 0;
   endtask

   // Frame timeline, in cycles after the tick: voice 0 is requested in
   // cycle 1, every later enabled voice one cycle after its turn comes up;
   // a request lasts 1 cycle (ack) or TMO cycles (timeout); a disabled voice
   // uses one cycle; SAT follows, one cycle later if the last voice was polled.
   task automatic start_frame();
      longint sl, sr;
      int t, s;
      sl = 0; sr = 0; t = 1;
      for (int i = 0; i < N; i++) begin
         rfrom[i] = -1; rto[i] = -2; tmo_v[i] = 0;
         if (voice_en[i]) begin
            s = (i == 0) ? t : t + 1;
            rfrom[i] = s;
            if (ack_mask[i] || spur) begin
               rto[i] = s;
               sl += $signed(vl[i]);
               sr += $signed(vr[i]);
            end else begin
               rto[i] = s + TMO - 1;
               tmo_v[i] = 1;
            end
            t = rto[i] + 1;
         end else begin
            t = t + 1;
         end
      end
      sat_k = voice_en[N-1] ? t + 1 : t;
      fsum  = {clamp(sl), clamp(sr)};
   endtask

   // compare + model step, once per falling edge
   initial begin
      logic [N-1:0] ereq;
      bit ewr, tick;
      model_reset();
      forever begin
         @(negedge clk);
         if (aclr) model_reset();
         ereq = '0;
         if (busy)
            for (int i = 0; i < N; i++)
               if (k >= rfrom[i] && k <= rto[i]) ereq[i] = 1'b1;
         ewr = busy && (k > sat_k) && !wrfull && enable && !aclr;
         chk("voice_req", voice_req, ereq);
         chk("wrreq", wrreq, ewr);
         chk("sample", sample, exp_sample);
         chk("missed_cnt", missed_cnt, exp_missed);
         chk("timeout_cnt", timeout_cnt, exp_tmo);
         for (int i = 0; i < N; i++) req_hi[i] += int'(voice_req[i]);
         req_ever = req_ever | voice_req;
         if (wrreq) begin n_wr++; wr_cyc = cyc; end
         if (!aclr) begin
            tick = enable && (mcnt == DIV - 1);
            mcnt = !enable ? 0 : (tick ? 0 : mcnt + 1);
            if (busy) begin
               if (!enable) busy = 0;
               else begin
                  for (int i = 0; i < N; i++)
                     if (tmo_v[i] && k == rto[i] && exp_tmo < 65535) exp_tmo++;
                  if (k == sat_k) exp_sample = fsum;
                  if (ewr) busy = 0;
                  k++;
                  if (tick && exp_missed < 65535) exp_missed++;
               end
            end else if (tick) begin
               start_frame();
               busy = 1; k = 1; tick_cyc = cyc; n_tick++;
            end
         end
      end
   end

   task automatic wait_wr(input int bound, input string name);
      int n0;
      bit got;
      n0 = n_wr; got = 0;
      for (int j = 0; j < bound && !got; j++) begin
         @(posedge clk); #3;
         if (n_wr != n0) got = 1;
      end
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL %s: no wrreq within %0d cycles", name, bound);
      end
   endtask

   task automatic wait_tick(input int bound, input string name);
      int n0;
      bit got;
      n0 = n_tick; got = 0;
      for (int j = 0; j < bound && !got; j++) begin
         @(posedge clk); #3;
         if (n_tick != n0) got = 1;
      end
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL %s: no tick within %0d cycles", name, bound);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int w0, fall_cyc, nwr0;
      aclr = 1; enable = 0; voice_en = '0; wrfull = 0; spur = 0;
      ack_mask = '1; req_ever = '0;
      for (int i = 0; i < N; i++) begin vl[i] = '0; vr[i] = '0; req_hi[i] = 0; end
      repeat (3) @(posedge clk);
      #2;
      chk("rst_voice_req", voice_req, 0);
      chk("rst_sample", sample, 0);
      chk("rst_wrreq", wrreq, 0);
      chk("rst_missed", missed_cnt, 0);
      chk("rst_timeout", timeout_cnt, 0);

      // 1: all voices ack at once, L=1024 R=4000
      for (int i = 0; i < N; i++) begin vl[i] = 32'd1024; vr[i] = 32'd4000; end
      voice_en = 4'b1111; aclr = 0; enable = 1;
      wait_wr(1200, "t1_wr");
      chk("t1_latency", wr_cyc - tick_cyc, 10);
      chk("t1_sample", sample, {32'd4096, 32'd16000});
      w0 = wr_cyc;
      wait_wr(1200, "t1_wr2");
      chk("t1_period", wr_cyc - w0, DIV);

      // 2: both channels saturate
      for (int i = 0; i < N; i++) begin vl[i] = 32'h7FFF_0000; vr[i] = 32'h8000_0001; end
      wait_wr(1200, "t2_wr");
      chk("t2_sample", sample, {32'h7FFF_FFFF, 32'h8000_0000});

      // 3: voice 2 never acks
      for (int i = 0; i < N; i++) begin vl[i] = 32'd1; vr[i] = 32'd1; req_hi[i] = 0; end
      ack_mask = 4'b1011;
      wait_wr(1200, "t3_wr");
      chk("t3_req2_cycles", req_hi[2], TMO);
      chk("t3_timeout_cnt", timeout_cnt, 1);
      chk("t3_sample", sample, {32'd3, 32'd3});

      // 4: FIFO full across two further ticks
      ack_mask = 4'b1111; wrfull = 1;
      wait_tick(1100, "t4_tick");
      repeat (3000) @(posedge clk);
      #2;
      chk("t4_no_wr_while_full", wrreq, 0);
      wrfull = 0; fall_cyc = cyc;
      wait_wr(5, "t4_wr");
      chk("t4_wr_after_fall", (wr_cyc >= fall_cyc) && (wr_cyc - fall_cyc <= 1), 1);
      chk("t4_missed", missed_cnt, 2);
      chk("t4_sample", sample, {32'd4, 32'd4});

      // 5: sparse mask, ack held high even without a request
      for (int i = 0; i < N; i++) begin vl[i] = 32'(100 * (i + 1)); vr[i] = 32'(-(i + 1)); end
      voice_en = 4'b0101; spur = 1; req_ever = '0;
      wait_wr(1200, "t5_wr");
      chk("t5_latency", wr_cyc - tick_cyc, 7);
      chk("t5_req_ever", req_ever, 4'b0101);
      chk("t5_sample", sample, {32'd400, 32'hFFFF_FFFC});

      // 6: enable drop mid-POLL, then asynchronous clear mid-frame
      spur = 0; voice_en = 4'b1111; ack_mask = 4'b1011; nwr0 = n_wr;
      wait_tick(1100, "t6_tick");
      chk("t6_req0_up", voice_req, 4'b0001);
      enable = 0;
      @(posedge clk); #3;
      chk("t6_req_drop", voice_req, 0);
      repeat (20) @(posedge clk);
      #2;
      chk("t6_no_wr", n_wr, nwr0);
      enable = 1;
      wait_tick(1100, "t6_tick2");
      repeat (4) @(posedge clk);
      #3;
      aclr = 1; enable = 0;
      #1;
      chk("t6_aclr_req", voice_req, 0);
      chk("t6_aclr_sample", sample, 0);
      chk("t6_aclr_wrreq", wrreq, 0);
      chk("t6_aclr_missed", missed_cnt, 0);
      chk("t6_aclr_timeout", timeout_cnt, 0);
      repeat (3) @(posedge clk);
      #2;
      aclr = 0;
      repeat (50) @(posedge clk);
      #2;
      chk("t6_no_wr_after", n_wr, nwr0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
